pipelined_cla_adder: RTL and testbench

- Parametrised, pipelined successor to the team's flat 32-bit CLA adder.
- Width is configurable, split into STAGES equal segments, one segment resolved per pipeline stage with the carry registered between stages.
- Adds carry-in, add/subtract mode, carry-out and signed-overflow flags, plus a valid/ready handshake with backpressure.
- Sits between operand-issue logic and any downstream consumer that needs wide sums at full clock rate.

---
 rtl/pipelined_cla_adder.sv | 167 ++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// pipelined_cla_adder
//
// Pipelined carry-lookahead adder/subtractor. The WIDTH-bit operands are cut
// into STAGES equal segments; each pipeline stage resolves one segment with a
// BLOCK-bit grouped CLA and registers the carry into the next stage. Upper
// operand segments travel down the pipe until their stage resolves them.
// A valid/ready handshake with full backpressure stalls the entire pipe.
//
// Parameters:
//   WIDTH   operand/sum width; must be a multiple of STAGES*BLOCK
//   STAGES  number of register stages (1..8)
//   BLOCK   CLA group size inside a segment (structural only)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   block can accept a beat this cycle
//   a, b       operands
//   cin        carry-in (borrow-in when sub=1)
//   sub        0: a+b+cin, 1: a-b-cin
//   out_valid  result beat valid
//   out_ready  consumer accepts result
//   sum        result modulo 2^WIDTH
//   cout       carry out of the MSB (sub=1: 1 means no borrow)
//   ovf        signed overflow
// -----------------------------------------------------------------------------
module pipelined_cla_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int BLOCK  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int DIV = ((STAGES > 0) && (BLOCK > 0)) ? STAGES * BLOCK : 1;
    localparam int SEG = (STAGES > 0) ? WIDTH / STAGES : WIDTH;

    if ((STAGES < 1) || (STAGES > 8) || (BLOCK < 1) || ((WIDTH % DIV) != 0)) begin : g_param_check
        $error("pipelined_cla_adder: WIDTH=%0d STAGES=%0d BLOCK=%0d is not a legal configuration",
               WIDTH, STAGES, BLOCK);
    end

    // One segment of the adder: BLOCK-bit lookahead groups whose carries
    // ripple group to group. Returns {carry_out, sum[SEG-1:0]}.
    function automatic logic [SEG:0] cla_segment(input logic [SEG-1:0] x,
                                                 input logic [SEG-1:0] y,
                                                 input logic           c_in);
        logic [SEG-1:0] p;
        logic [SEG-1:0] g;
        logic [SEG:0]   c;
        logic           grp_g;
        logic           grp_p;
        p    = x ^ y;
        g    = x & y;
        c    = '0;
        c[0] = c_in;
        for (int j = 0; j < SEG / BLOCK; j++) begin
            // Prefix generate/propagate over the bits of this group seen so
            // far; each bit carry comes straight from the group carry-in.
            grp_g = 1'b0;
            grp_p = 1'b1;
            for (int i = 0; i < BLOCK; i++) begin
                c[j*BLOCK + i] = grp_g | (grp_p & c[j*BLOCK]);
                grp_g = g[j*BLOCK + i] | (p[j*BLOCK + i] & grp_g);
                grp_p = grp_p & p[j*BLOCK + i];
            end
            c[(j+1)*BLOCK] = grp_g | (grp_p & c[j*BLOCK]);
        end
        return {c[SEG], p ^ c[SEG-1:0]};
    endfunction

    // The whole pipe moves together; a stalled output freezes every stage.
    logic advance;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IN_W = WIDTH - k * SEG;   // operand bits not yet resolved

        logic [IN_W-1:0]        in_a;
        logic [IN_W-1:0]        in_b;
        logic                   in_c;
        logic                   in_v;
        logic [SEG:0]           seg_res;
        logic [(k+1)*SEG-1:0]   next_sum;

        logic                   valid_q;
        logic                   carry_q;
        logic [(k+1)*SEG-1:0]   sum_q;

        if (k == 0) begin : g_src
            // Subtraction is a + ~b + ~cin, so the borrow-in becomes carry-in.
            assign in_a     = a;
            assign in_b     = b ^ {WIDTH{sub}};
            assign in_c     = cin ^ sub;
            assign in_v     = in_valid;
            assign next_sum = seg_res[SEG-1:0];
        end else begin : g_src
            assign in_a     = g_stage[k-1].g_ops.a_q;
            assign in_b     = g_stage[k-1].g_ops.b_q;
            assign in_c     = g_stage[k-1].carry_q;
            assign in_v     = g_stage[k-1].valid_q;
            assign next_sum = {seg_res[SEG-1:0], g_stage[k-1].sum_q};
        end

        assign seg_res = cla_segment(in_a[SEG-1:0], in_b[SEG-1:0], in_c);

        // NOTE: sequential state uses non-blocking assignments so every stage
        // samples its predecessor's pre-edge value and the pipe shifts cleanly.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (advance) begin
                valid_q <= in_v;
                carry_q <= seg_res[SEG];
                sum_q   <= next_sum;
            end
        end

        if (k < STAGES - 1) begin : g_ops
            logic [IN_W-SEG-1:0] a_q;
            logic [IN_W-SEG-1:0] b_q;

            // NOTE: operand registers carry no reset; their contents are only
            // observed behind a valid bit, so a reset would buy nothing.
            always_ff @(posedge clk) begin
                if (advance) begin
                    a_q <= in_a[IN_W-1:SEG];
                    b_q <= in_b[IN_W-1:SEG];
                end
            end
        end else begin : g_msb
            // Carry into the MSB, recovered from sum = p ^ carry at that bit.
            logic cmsb_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    cmsb_q <= 1'b0;
                end else if (advance) begin
                    cmsb_q <= in_a[SEG-1] ^ in_b[SEG-1] ^ seg_res[SEG-1];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign cout      = g_stage[STAGES-1].carry_q;
    assign ovf       = g_stage[STAGES-1].g_msb.cmsb_q ^ g_stage[STAGES-1].carry_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_cla_adder
//
// Exercises three configurations side by side on one clock:
//   index 0: WIDTH=32, STAGES=2
//   index 1: WIDTH=64, STAGES=1
//   index 2: WIDTH=64, STAGES=4
// Directed vectors come from a table of hand-derived results; streams of
// random beats with random backpressure are checked against an arithmetic
// reference model through an in-order scoreboard queue.
// -----------------------------------------------------------------------------
module tb_pipelined_cla_adder;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct {
        int          idx;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        res_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [63:0] a_s [3];
    logic [63:0] b_s [3];
    logic [2:0]  in_valid_v;
    logic [2:0]  out_ready_v;
    logic [2:0]  cin_v;
    logic [2:0]  sub_v;
    wire  [2:0]  in_ready_v;
    wire  [2:0]  out_valid_v;
    wire  [2:0]  cout_v;
    wire  [2:0]  ovf_v;
    wire  [31:0] sum0;
    wire  [63:0] sum1;
    wire  [63:0] sum2;

    int n_cmp = 0;
    int n_bad = 0;
    int width_of  [3] = '{32, 64, 64};
    int stages_of [3] = '{2, 1, 4};

    pipelined_cla_adder #(.WIDTH(32), .STAGES(2), .BLOCK(4)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_s[0][31:0]), .b(b_s[0][31:0]), .cin(cin_v[0]), .sub(sub_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .sum(sum0), .cout(cout_v[0]), .ovf(ovf_v[0])
    );

    pipelined_cla_adder #(.WIDTH(64), .STAGES(1), .BLOCK(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_s[1]), .b(b_s[1]), .cin(cin_v[1]), .sub(sub_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .sum(sum1), .cout(cout_v[1]), .ovf(ovf_v[1])
    );

    pipelined_cla_adder #(.WIDTH(64), .STAGES(4), .BLOCK(4)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_s[2]), .b(b_s[2]), .cin(cin_v[2]), .sub(sub_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .sum(sum2), .cout(cout_v[2]), .ovf(ovf_v[2])
    );

    function automatic res_t get_res(input int idx);
        res_t r;
        case (idx)
            0:       r.sum = {32'h0, sum0};
            1:       r.sum = sum1;
            default: r.sum = sum2;
        endcase
        r.cout = cout_v[idx];
        r.ovf  = ovf_v[idx];
        return r;
    endfunction

    // Reference: plain wide unsigned and signed arithmetic on the operands.
    function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub);
        logic [63:0]        mask;
        logic [67:0]        ua, ub, ur;
        logic signed [67:0] sa, sb, sr, sc, smax, smin;
        res_t               r;
        mask = (w == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
        ua   = {4'b0, a & mask};
        ub   = {4'b0, b & mask};
        sc   = $signed({67'b0, cin});
        if (w == 64) begin
            sa = {{4{a[63]}}, a};
            sb = {{4{b[63]}}, b};
        end else begin
            sa = {{36{a[31]}}, a[31:0]};
            sb = {{36{b[31]}}, b[31:0]};
        end
        smax = (68'sd1 <<< (w - 1)) - 68'sd1;
        smin = -(68'sd1 <<< (w - 1));
        if (!sub) begin
            ur     = ua + ub + {67'b0, cin};
            sr     = sa + sb + sc;
            r.cout = ur[w];
        end else begin
            ur     = ua - ub - {67'b0, cin};
            sr     = sa - sb - sc;
            r.cout = (ua >= ub + {67'b0, cin});
        end
        r.sum = ur[63:0] & mask;
        r.ovf = (sr > smax) || (sr < smin);
        return r;
    endfunction

    function automatic logic [63:0] rand_operand(input int w);
        logic [63:0] v;
        case ($urandom % 8)
            0:       v = {64{1'b1}};
            1:       v = 64'h0;
            2:       v = 64'h7FFF_FFFF_FFFF_FFFF >> (64 - w);
            default: v = {$urandom, $urandom};
        endcase
        return (w == 64) ? v : (v & 64'h0000_0000_FFFF_FFFF);
    endfunction

    function automatic vec_t mk(input int idx, input logic [63:0] a, input logic [63:0] b,
                                input logic cin, input logic sub,
                                input logic [63:0] s, input logic co, input logic ov);
        vec_t v;
        v.idx      = idx;
        v.a        = a;
        v.b        = b;
        v.cin      = cin;
        v.sub      = sub;
        v.exp.sum  = s;
        v.exp.cout = co;
        v.exp.ovf  = ov;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Single beat into an empty pipe; checks acceptance, latency and result.
    task automatic apply_vec(input vec_t v);
        int   lat;
        res_t r;
        @(negedge clk);
        a_s[v.idx]         = v.a;
        b_s[v.idx]         = v.b;
        cin_v[v.idx]       = v.cin;
        sub_v[v.idx]       = v.sub;
        in_valid_v[v.idx]  = 1'b1;
        out_ready_v[v.idx] = 1'b1;
        #1;
        check("vec_in_ready", {63'b0, in_ready_v[v.idx]}, 64'd1);
        @(negedge clk);
        in_valid_v[v.idx] = 1'b0;
        a_s[v.idx]        = rand_operand(width_of[v.idx]);
        b_s[v.idx]        = rand_operand(width_of[v.idx]);
        lat = 0;
        while (!out_valid_v[v.idx] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("vec_latency", 64'(lat), 64'(stages_of[v.idx] - 1));
        r = get_res(v.idx);
        check("vec_sum",  r.sum,          v.exp.sum);
        check("vec_cout", {63'b0, r.cout}, {63'b0, v.exp.cout});
        check("vec_ovf",  {63'b0, r.ovf},  {63'b0, v.exp.ovf});
    endtask

    // Random beats with random backpressure, scoreboarded in order.
    task automatic run_stream(input int idx, input int n, input int max_cycles);
        res_t        q[$];
        res_t        r;
        int          sent = 0;
        int          rcvd = 0;
        int          cyc  = 0;
        bit          prev_stall = 1'b0;
        int          w = width_of[idx];
        logic [63:0] ta, tb;
        logic        tc, ts;
        while ((sent < n || rcvd < n) && cyc < max_cycles) begin
            @(negedge clk);
            cyc++;
            ta = rand_operand(w);
            tb = rand_operand(w);
            tc = 1'($urandom % 2);
            ts = 1'($urandom % 2);
            a_s[idx]         = ta;
            b_s[idx]         = tb;
            cin_v[idx]       = tc;
            sub_v[idx]       = ts;
            out_ready_v[idx] = ($urandom % 3 != 0);
            in_valid_v[idx]  = (sent < n) && ($urandom % 4 != 0);
            #1;
            if (prev_stall)
                check("stall_hold_valid", {63'b0, out_valid_v[idx]}, 64'd1);
            if (out_valid_v[idx]) begin
                if (q.size() == 0) begin
                    check("spurious_valid", {63'b0, out_valid_v[idx]}, 64'd0);
                end else begin
                    r = get_res(idx);
                    check("stream_sum",  r.sum,           q[0].sum);
                    check("stream_cout", {63'b0, r.cout}, {63'b0, q[0].cout});
                    check("stream_ovf",  {63'b0, r.ovf},  {63'b0, q[0].ovf});
                end
            end
            prev_stall = out_valid_v[idx] && !out_ready_v[idx];
            if (out_valid_v[idx] && out_ready_v[idx] && q.size() > 0) begin
                void'(q.pop_front());
                rcvd++;
            end
            if (in_valid_v[idx] && in_ready_v[idx]) begin
                q.push_back(model(w, ta, tb, tc, ts));
                sent++;
            end
        end
        in_valid_v[idx]  = 1'b0;
        out_ready_v[idx] = 1'b1;
        check("stream_sent",     64'(sent), 64'(n));
        check("stream_received", 64'(rcvd), 64'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl [14];
        res_t r;

        rst         = 1'b1;
        in_valid_v  = '0;
        out_ready_v = '0;
        cin_v       = '0;
        sub_v       = '0;
        for (int i = 0; i < 3; i++) begin
            a_s[i] = '0;
            b_s[i] = '0;
        end

        // Reset state.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            r = get_res(i);
            check("rst_out_valid", {63'b0, out_valid_v[i]}, 64'd0);
            check("rst_sum",       r.sum,                   64'd0);
            check("rst_cout",      {63'b0, r.cout},         64'd0);
            check("rst_ovf",       {63'b0, r.ovf},          64'd0);
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++)
            check("rst_in_ready", {63'b0, in_ready_v[i]}, 64'd1);
        out_ready_v = '1;

        // Directed vectors with hand-derived results.
        tbl[0]  = mk(0, 64'hFFFF_FFFF, 64'h1,         1'b0, 1'b0, 64'h0,          1'b1, 1'b0);
        tbl[1]  = mk(0, 64'h7FFF_FFFF, 64'h1,         1'b0, 1'b0, 64'h8000_0000,  1'b0, 1'b1);
        tbl[2]  = mk(0, 64'h5,         64'h7,         1'b0, 1'b1, 64'hFFFF_FFFE,  1'b0, 1'b0);
        tbl[3]  = mk(0, 64'h10,        64'h3,         1'b1, 1'b1, 64'hC,          1'b1, 1'b0);
        tbl[4]  = mk(0, 64'hFFFF_FFFF, 64'h0,         1'b1, 1'b0, 64'h0,          1'b1, 1'b0);
        tbl[5]  = mk(0, 64'h8000_0000, 64'h1,         1'b0, 1'b1, 64'h7FFF_FFFF,  1'b1, 1'b1);
        tbl[6]  = mk(0, 64'h0,         64'h0,         1'b0, 1'b1, 64'h0,          1'b1, 1'b0);
        tbl[7]  = mk(0, 64'h0,         64'h0,         1'b1, 1'b1, 64'hFFFF_FFFF,  1'b0, 1'b0);
        tbl[8]  = mk(0, 64'h0000_FFFF, 64'h1,         1'b0, 1'b0, 64'h0001_0000,  1'b0, 1'b0);
        tbl[9]  = mk(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0,        1'b1, 1'b0);
        tbl[10] = mk(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0,        1'b1, 1'b0);
        tbl[11] = mk(2, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                     64'h8000_0000_0000_0000, 1'b0, 1'b1);
        tbl[12] = mk(1, 64'h0,         64'h1,         1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        tbl[13] = mk(2, 64'h1_0000,    64'h1,         1'b1, 1'b1, 64'hFFFE,       1'b1, 1'b0);
        for (int i = 0; i < 14; i++)
            apply_vec(tbl[i]);

        // Reset with two beats in flight on the 2-stage instance.
        @(negedge clk);
        a_s[0] = 64'h1; b_s[0] = 64'h1; cin_v[0] = 1'b0; sub_v[0] = 1'b0;
        in_valid_v[0] = 1'b1; out_ready_v[0] = 1'b0;
        @(negedge clk);
        a_s[0] = 64'h2; b_s[0] = 64'h2;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        check("inflight_valid", {63'b0, out_valid_v[0]}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        r = get_res(0);
        check("midrst_out_valid", {63'b0, out_valid_v[0]}, 64'd0);
        check("midrst_sum",       r.sum,                   64'd0);
        check("midrst_cout",      {63'b0, r.cout},         64'd0);
        check("midrst_ovf",       {63'b0, r.ovf},          64'd0);
        #1;
        check("midrst_in_ready",  {63'b0, in_ready_v[0]},  64'd1);
        out_ready_v[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_no_ghost", {63'b0, out_valid_v[0]}, 64'd0);
        end
        apply_vec(mk(0, 64'h1234_5678, 64'h1111_1111, 1'b0, 1'b0, 64'h2345_6789, 1'b0, 1'b0));

        // Random streams with backpressure.
        run_stream(0, 16, 400);
        run_stream(1, 1000, 6000);
        run_stream(2, 1000, 6000);

        // Latency on the 64-bit instances with model-derived results.
        for (int i = 0; i < 3; i++) begin
            for (int d = 1; d < 3; d++) begin
                vec_t v;
                v.idx = d;
                v.a   = rand_operand(64);
                v.b   = rand_operand(64);
                v.cin = 1'($urandom % 2);
                v.sub = 1'($urandom % 2);
                v.exp = model(64, v.a, v.b, v.cin, v.sub);
                apply_vec(v);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
